// File: rtl/hiscore_pkg.sv
`default_nettype none
// ============================================================================
// Module : hiscore_pkg
// Brief  : Shared state encoding and default constants for the hiscore arbiter
// Rev    : 1.0  initial release
// ============================================================================
package hiscore_pkg;

    localparam int c_DEFAULT_AW          = 11;
    localparam int c_DEFAULT_SETTLE      = 4;
    localparam int c_DEFAULT_HOLD        = 2;
    localparam int c_DEFAULT_VBL_TIMEOUT = 1048576;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_VBL = 3'd1,
        ST_HALT     = 3'd2,
        ST_GRANT    = 3'd3,
        ST_RELEASE  = 3'd4
    } hs_state_t;

endpackage
`default_nettype wire

// File: rtl/hiscore_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : hiscore_ram_arbiter
// Brief  : Halts the game CPU around vblank and hands the work RAM to the
//          hiscore engine, muxing the RAM port between the two masters.
// Rev    : 1.0  initial release
// ============================================================================
module hiscore_ram_arbiter
    import hiscore_pkg::*;
#(
    parameter int AW          = c_DEFAULT_AW,
    parameter int SETTLE      = c_DEFAULT_SETTLE,
    parameter int HOLD        = c_DEFAULT_HOLD,
    parameter int VBL_TIMEOUT = c_DEFAULT_VBL_TIMEOUT
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          vblank,
    input  logic          user_pause,
    input  logic          hs_req,
    output logic          hs_grant,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_din,
    input  logic          hs_we,
    output logic [7:0]    hs_dout,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_we,
    output logic [7:0]    cpu_dout,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    output logic          cpu_pause
);

    localparam int c_DLY_MAX = (SETTLE > HOLD) ? SETTLE : HOLD;
    localparam int c_DW      = (c_DLY_MAX > 1) ? $clog2(c_DLY_MAX) : 1;
    localparam int c_WW      = (VBL_TIMEOUT > 1) ? $clog2(VBL_TIMEOUT) : 1;

    localparam logic [c_DW-1:0] c_SETTLE_LD = c_DW'(SETTLE - 1);
    localparam logic [c_DW-1:0] c_HOLD_LD   = c_DW'(HOLD - 1);
    localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(VBL_TIMEOUT - 1);

    hs_state_t       r_state, w_state_nxt;
    logic            r_vbl_d;
    logic            r_halt, w_halt_nxt;
    logic [c_DW-1:0] r_dly, w_dly_nxt;
    logic [c_WW-1:0] r_wait, w_wait_nxt;

    logic w_vbl_rise;
    logic w_grant;
    logic w_cpu_pause;

    assign w_vbl_rise = vblank & ~r_vbl_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_vbl_d <= 1'b0;
            r_halt  <= 1'b0;
            r_dly   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vbl_d <= vblank;
            r_halt  <= w_halt_nxt;
            r_dly   <= w_dly_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // One delay counter serves both the settle time before grant and the hold
    // time after it; the two phases can never overlap.
    always_comb begin
        w_state_nxt = r_state;
        w_halt_nxt  = r_halt;
        w_dly_nxt   = r_dly;
        w_wait_nxt  = r_wait;
        case (r_state)
            ST_IDLE: begin
                w_wait_nxt = '0;
                if (hs_req) begin
                    if (user_pause) begin
                        w_state_nxt = ST_HALT;
                        w_halt_nxt  = 1'b1;
                        w_dly_nxt   = c_SETTLE_LD;
                    end else begin
                        w_state_nxt = ST_WAIT_VBL;
                    end
                end
            end
            ST_WAIT_VBL: begin
                if (!hs_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_vbl_rise || (r_wait == c_WAIT_LAST)) begin
                    w_state_nxt = ST_HALT;
                    w_halt_nxt  = 1'b1;
                    w_dly_nxt   = c_SETTLE_LD;
                end else begin
                    w_wait_nxt = r_wait + c_WW'(1);
                end
            end
            ST_HALT: begin
                if (!hs_req) begin
                    w_state_nxt = ST_RELEASE;
                    w_dly_nxt   = c_HOLD_LD;
                end else if (r_dly == '0) begin
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_dly_nxt = r_dly - c_DW'(1);
                end
            end
            ST_GRANT: begin
                if (!hs_req) begin
                    w_state_nxt = ST_RELEASE;
                    w_dly_nxt   = c_HOLD_LD;
                end
            end
            ST_RELEASE: begin
                if (r_dly == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_halt_nxt  = 1'b0;
                end else begin
                    w_dly_nxt = r_dly - c_DW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_halt_nxt  = 1'b0;
            end
        endcase
    end

    assign w_grant     = (r_state == ST_GRANT);
    assign w_cpu_pause = user_pause | r_halt;

    assign hs_grant  = w_grant;
    assign cpu_pause = w_cpu_pause;
    assign ram_addr  = w_grant ? hs_addr : cpu_addr;
    assign ram_din   = w_grant ? hs_din  : cpu_din;
    assign ram_we    = w_grant ? hs_we   : (cpu_we & ~w_cpu_pause);
    assign hs_dout   = ram_dout;
    assign cpu_dout  = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_hiscore_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_hiscore_ram_arbiter
// Brief  : Self-checking bench: timestamp-based reference model plus directed
//          literal scenarios and a randomized run.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hiscore_ram_arbiter;

    localparam int AW     = 11;
    localparam int SETTLE = 4;
    localparam int HOLD   = 2;
    localparam int VT     = 16;

    logic          clk_sys    = 1'b0;
    logic          reset_n    = 1'b0;
    logic          vblank     = 1'b0;
    logic          user_pause = 1'b0;
    logic          hs_req     = 1'b0;
    logic          hs_grant;
    logic [AW-1:0] hs_addr    = '0;
    logic [7:0]    hs_din     = '0;
    logic          hs_we      = 1'b0;
    logic [7:0]    hs_dout;
    logic [AW-1:0] cpu_addr   = '0;
    logic [7:0]    cpu_din    = '0;
    logic          cpu_we     = 1'b0;
    logic [7:0]    cpu_dout;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout   = '0;
    logic          cpu_pause;

    hiscore_ram_arbiter #(
        .AW(AW), .SETTLE(SETTLE), .HOLD(HOLD), .VBL_TIMEOUT(VT)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .vblank(vblank), .user_pause(user_pause),
        .hs_req(hs_req), .hs_grant(hs_grant), .hs_addr(hs_addr), .hs_din(hs_din),
        .hs_we(hs_we), .hs_dout(hs_dout), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_we(cpu_we), .cpu_dout(cpu_dout), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout), .cpu_pause(cpu_pause)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases plus absolute edge-count deadlines.
    localparam int M_IDLE = 0, M_WAIT = 1, M_HALT = 2, M_GRANT = 3, M_REL = 4;
    int   m_phase    = M_IDLE;
    int   m_edge     = 0;
    int   m_deadline = 0;
    logic m_vprev    = 1'b0;

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = M_IDLE;
            m_edge  = 0;
            m_vprev = 1'b0;
        end else begin
            m_edge++;
            case (m_phase)
                M_IDLE: if (hs_req) begin
                    if (user_pause) begin
                        m_phase = M_HALT;  m_deadline = m_edge + SETTLE;
                    end else begin
                        m_phase = M_WAIT;  m_deadline = m_edge + VT;
                    end
                end
                M_WAIT: if (!hs_req) m_phase = M_IDLE;
                    else if ((vblank && !m_vprev) || m_edge == m_deadline) begin
                        m_phase = M_HALT;  m_deadline = m_edge + SETTLE;
                    end
                M_HALT: if (!hs_req) begin
                        m_phase = M_REL;   m_deadline = m_edge + HOLD;
                    end else if (m_edge == m_deadline) m_phase = M_GRANT;
                M_GRANT: if (!hs_req) begin
                        m_phase = M_REL;   m_deadline = m_edge + HOLD;
                    end
                M_REL: if (m_edge == m_deadline) m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
            m_vprev = vblank;
        end
    end

    logic e_grant, e_halt, e_pause;
    always @(negedge clk_sys) begin
        e_grant = (m_phase == M_GRANT);
        e_halt  = (m_phase == M_HALT) || (m_phase == M_GRANT) || (m_phase == M_REL);
        e_pause = user_pause | e_halt;
        chk("m_hs_grant", hs_grant, e_grant);
        chk("m_cpu_pause", cpu_pause, e_pause);
        chk("m_ram_addr", ram_addr, e_grant ? hs_addr : cpu_addr);
        chk("m_ram_din", ram_din, e_grant ? hs_din : cpu_din);
        chk("m_ram_we", ram_we, e_grant ? hs_we : (cpu_we & ~e_pause));
        chk("m_hs_dout", hs_dout, ram_dout);
        chk("m_cpu_dout", cpu_dout, ram_dout);
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        repeat (3) step();
        #1;
        chk("rst_grant", hs_grant, 1'b0);
        chk("rst_pause", cpu_pause, 1'b0);
        reset_n = 1'b1;
        cpu_we = 1'b1;
        step();
        chk("post_rst_ram_we", ram_we, 1'b1);

        // vblank-triggered halt, settle, grant, then release with hold
        hs_req = 1'b1;
        repeat (3) step();
        chk("wait_no_pause", cpu_pause, 1'b0);
        vblank = 1'b1;
        step();
        chk("halt_pause", cpu_pause, 1'b1);
        chk("halt_no_grant", hs_grant, 1'b0);
        chk("halt_cpu_we_blocked", ram_we, 1'b0);
        repeat (3) step();
        chk("settle_no_grant", hs_grant, 1'b0);
        step();
        chk("grant_on_time", hs_grant, 1'b1);
        hs_addr = 11'h7F0; hs_we = 1'b1; hs_din = 8'hA5;
        cpu_addr = 11'h010; cpu_we = 1'b1; cpu_din = 8'h5A; ram_dout = 8'h3C;
        #1;
        chk("grant_ram_addr", ram_addr, 11'h7F0);
        chk("grant_ram_din", ram_din, 8'hA5);
        chk("grant_ram_we", ram_we, 1'b1);
        chk("grant_hs_dout", hs_dout, 8'h3C);
        chk("grant_cpu_dout", cpu_dout, 8'h3C);
        hs_req = 1'b0;
        step();
        chk("rel_grant_off", hs_grant, 1'b0);
        chk("rel_hs_we_ignored", ram_we, 1'b0);
        chk("rel_pause_1", cpu_pause, 1'b1);
        step();
        chk("rel_pause_2", cpu_pause, 1'b1);
        step();
        chk("rel_done_pause", cpu_pause, 1'b0);
        chk("rel_done_ram_we", ram_we, 1'b1);
        chk("rel_done_ram_addr", ram_addr, 11'h010);

        // vblank timeout path, then asynchronous reset mid-grant
        vblank = 1'b0;
        hs_req = 1'b1;
        step();
        repeat (15) step();
        chk("timeout_not_yet", cpu_pause, 1'b0);
        step();
        chk("timeout_halt", cpu_pause, 1'b1);
        repeat (3) step();
        chk("timeout_no_grant", hs_grant, 1'b0);
        step();
        chk("timeout_grant", hs_grant, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_grant", hs_grant, 1'b0);
        chk("async_rst_pause", cpu_pause, 1'b0);
        step();
        reset_n = 1'b1;
        hs_req = 1'b0;
        step();
        chk("after_rst_grant", hs_grant, 1'b0);

        // user pause: no vblank wait, CPU writes never reach RAM
        user_pause = 1'b1; cpu_we = 1'b1; hs_we = 1'b0; hs_req = 1'b1;
        step();
        chk("up_halt_pause", cpu_pause, 1'b1);
        chk("up_ram_we", ram_we, 1'b0);
        repeat (3) step();
        chk("up_no_grant", hs_grant, 1'b0);
        step();
        chk("up_grant", hs_grant, 1'b1);
        user_pause = 1'b0;
        step();
        chk("up_fall_still_halted", cpu_pause, 1'b1);
        user_pause = 1'b1;
        hs_req = 1'b0;
        repeat (3) step();
        chk("up_idle_pause", cpu_pause, 1'b1);
        chk("up_idle_ram_we", ram_we, 1'b0);
        user_pause = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 24) == 0) hs_req = ~hs_req;
            if ($urandom_range(0, (i < 1500) ? 5 : 40) == 0) vblank = ~vblank;
            if ($urandom_range(0, 59) == 0) user_pause = ~user_pause;
            hs_addr  = AW'($urandom);
            cpu_addr = AW'($urandom);
            hs_din   = 8'($urandom);
            cpu_din  = 8'($urandom);
            hs_we    = 1'($urandom_range(0, 1));
            cpu_we   = 1'($urandom_range(0, 1));
            ram_dout = 8'($urandom);
        end
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
